// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame sequencer: FSM state encoding,
// default frame-length limits and the frame-length legality check.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_MIN_PTS = 64;
    localparam int DEF_MAX_PTS = 1024;

    // Legal frame lengths are powers of two inside [min_pts, max_pts].
    function automatic logic pts_legal(input int unsigned pts,
                                       input int unsigned min_pts,
                                       input int unsigned max_pts);
        return (pts >= min_pts) && (pts <= max_pts) && ((pts & (pts - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/fft_out_checker.sv
// Source-side tracker: counts output beats, checks sop/eop placement, accumulates
// the sticky core error and (with FFT_CTRL_TIMEOUT_EN) runs the drain watchdog.
module fft_out_checker #(
    parameter int PTS_W       = 11,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_drain,
    input  logic             clr,
    input  logic [PTS_W-1:0] fft_pts,
    input  logic             src_valid,
    input  logic             src_sop,
    input  logic             src_eop,
    input  logic [1:0]       src_error,
    output logic             timeout,
    output logic             err_core
);

    logic [PTS_W-1:0] out_cnt;
    logic [PTS_W-1:0] last_idx;
    logic             bad;

    assign last_idx = fft_pts - PTS_W'(1);

    always_comb begin
        bad = 1'b0;
        if (src_valid) begin
            // Any output beat outside the drain window means the core and the
            // sequencer have lost frame alignment.
            if (!in_drain)
                bad = 1'b1;
            else begin
                if (src_sop && (out_cnt != '0))
                    bad = 1'b1;
                if (src_eop && (out_cnt != last_idx))
                    bad = 1'b1;
                if (src_error != 2'b00)
                    bad = 1'b1;
            end
        end
        if (timeout)
            bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt  <= '0;
            err_core <= 1'b0;
        end else begin
            if (clr)
                out_cnt <= '0;
            else if (in_drain && src_valid)
                out_cnt <= out_cnt + PTS_W'(1);
            if (bad)
                err_core <= 1'b1;
        end
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || !in_drain)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign timeout = in_drain && !(src_valid && src_eop) &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout        = 1'b0;
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between the ADC stream and the streaming FFT core sink/source.
// Optional drain watchdog enabled by defining FFT_CTRL_TIMEOUT_EN.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int PTS_W       = 11,
    parameter int MIN_PTS     = DEF_MIN_PTS,
    parameter int MAX_PTS     = DEF_MAX_PTS,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic [PTS_W-1:0]  cfg_pts,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [DATA_W-1:0] smp_data,
    output logic              fft_sink_valid,
    output logic              fft_sink_sop,
    output logic              fft_sink_eop,
    input  logic              fft_sink_ready,
    output logic [DATA_W-1:0] fft_sink_real,
    output logic [DATA_W-1:0] fft_sink_imag,
    output logic [1:0]        fft_sink_error,
    output logic [PTS_W-1:0]  fft_pts,
    output logic              fft_inverse,
    input  logic              fft_source_valid,
    input  logic              fft_source_sop,
    input  logic              fft_source_eop,
    input  logic [1:0]        fft_source_error,
    output logic              fft_source_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_core,
    output logic              err_cfg,
    output logic [15:0]       frame_cnt
);

    state_t            state, state_nxt;
    logic [PTS_W-1:0]  in_cnt;
    logic [DATA_W-1:0] last_data;
    logic              in_feed, in_drain, cfg_ok, xfer, src_last;
    logic              frame_start, err_cfg_nxt, timeout;

    assign in_feed  = (state == FEED);
    assign in_drain = (state == DRAIN);
    assign cfg_ok   = pts_legal(32'(cfg_pts), MIN_PTS, MAX_PTS);
    assign xfer     = in_feed && smp_valid && fft_sink_ready;
    assign src_last = in_drain && fft_source_valid && fft_source_eop;

    // Sink side is a pure pass-through while feeding; data holds between frames.
    assign smp_ready        = in_feed && fft_sink_ready;
    assign fft_sink_valid   = in_feed && smp_valid;
    assign fft_sink_sop     = in_feed && (in_cnt == '0);
    assign fft_sink_eop     = in_feed && (in_cnt == fft_pts - PTS_W'(1));
    assign fft_sink_real    = in_feed ? smp_data : last_data;
    assign fft_sink_imag    = '0;
    assign fft_sink_error   = 2'b00;
    assign fft_inverse      = 1'b0;
    assign fft_source_ready = 1'b1;
    assign busy             = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        err_cfg_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start || cont) begin
                    if (cfg_ok) begin
                        state_nxt   = FEED;
                        frame_start = 1'b1;
                    end else begin
                        err_cfg_nxt = 1'b1;
                    end
                end
            end
            FEED: begin
                if (xfer && fft_sink_eop)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (src_last) begin
                    // Continuous re-arm goes through the same legality check as IDLE.
                    if (cont && cfg_ok) begin
                        state_nxt   = FEED;
                        frame_start = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        err_cfg_nxt = cont;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_cnt     <= '0;
            fft_pts    <= PTS_W'(MAX_PTS);
            last_data  <= '0;
            frame_done <= 1'b0;
            err_cfg    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= src_last;
            err_cfg    <= err_cfg_nxt;
            if (src_last)
                frame_cnt <= frame_cnt + 16'd1;
            if (frame_start) begin
                fft_pts <= cfg_pts;
                in_cnt  <= '0;
            end else if (xfer) begin
                in_cnt <= in_cnt + PTS_W'(1);
            end
            if (xfer)
                last_data <= smp_data;
        end
    end

    fft_out_checker #(
        .PTS_W       (PTS_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_out_checker (
        .clk       (clk),
        .reset     (reset),
        .in_drain  (in_drain),
        .clr       (frame_start),
        .fft_pts   (fft_pts),
        .src_valid (fft_source_valid),
        .src_sop   (fft_source_sop),
        .src_eop   (fft_source_eop),
        .src_error (fft_source_error),
        .timeout   (timeout),
        .err_core  (err_core)
    );

endmodule
